// File: rtl/multi_lock_monitor_pkg.sv
// Shared types and width helper for the multi-channel lock monitor.
package multi_lock_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCK   = 2'd0,
    ACQUIRE  = 2'd1,
    LOCK     = 2'd2,
    HOLDOVER = 2'd3
  } lock_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_lock_monitor_if.sv
// Edge/clear inputs and lock status outputs of the multi-channel lock monitor.
interface multi_lock_monitor_if #(
  parameter int NUM_CH = 1
);
  logic [NUM_CH-1:0]   clear;
  logic [NUM_CH-1:0]   rise_edge;
  logic [NUM_CH-1:0]   locked;
  logic [NUM_CH-1:0]   lock_lost;
  logic [2*NUM_CH-1:0] state_o;
  logic                all_locked;
  logic                any_lost;

  modport master (
    output clear, rise_edge,
    input  locked, lock_lost, state_o, all_locked, any_lost
  );

  modport slave (
    input  clear, rise_edge,
    output locked, lock_lost, state_o, all_locked, any_lost
  );
endinterface

// File: rtl/multi_lock_monitor_ch.sv
// One channel: edge-count acquisition, holdover through missed windows, lock-loss pulse.
module lock_monitor_ch
  import multi_lock_monitor_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 255,
  parameter int MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        rise_edge,
  output logic        locked,
  output logic        lock_lost,
  output lock_state_e state
);

  localparam int GAP_W  = cnt_width(TIMEOUT);
  localparam int ACQ_W  = cnt_width(LOCK_COUNT + 1);
  localparam int MISS_W = cnt_width(MISS_LIMIT + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
  localparam logic [ACQ_W-1:0]  ACQ_LAST  = ACQ_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  logic [GAP_W-1:0]  gap;
  logic [ACQ_W-1:0]  acq;
  logic [MISS_W-1:0] miss;
  logic              timeout;

  // An edge in the same cycle always wins over the window expiring.
  assign timeout = (state != UNLOCK) && !rise_edge && (gap == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCK;
      gap       <= '0;
      acq       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else if (clear) begin
      state     <= UNLOCK;
      gap       <= '0;
      acq       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      locked    <= (state == LOCK) || (state == HOLDOVER);

      if (state == UNLOCK || rise_edge || gap == GAP_LAST) gap <= '0;
      else                                                  gap <= gap + 1'b1;

      unique case (state)
        UNLOCK: begin
          if (rise_edge) begin
            acq   <= ACQ_W'(1);
            state <= (LOCK_COUNT == 1) ? LOCK : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (rise_edge) begin
            acq <= acq + 1'b1;
            if (acq == ACQ_LAST) state <= LOCK;
          end else if (timeout) begin
            acq   <= '0;
            state <= UNLOCK;
          end
        end
        LOCK: begin
          if (rise_edge) begin
            miss <= '0;
          end else if (timeout) begin
            if (MISS_LIMIT == 1) begin
              state     <= UNLOCK;
              lock_lost <= 1'b1;
              acq       <= '0;
              miss      <= '0;
            end else begin
              miss  <= MISS_W'(1);
              state <= HOLDOVER;
            end
          end
        end
        HOLDOVER: begin
          if (rise_edge) begin
            miss  <= '0;
            state <= LOCK;
          end else if (timeout) begin
            if (miss == MISS_LAST) begin
              state     <= UNLOCK;
              lock_lost <= 1'b1;
              acq       <= '0;
              miss      <= '0;
            end else begin
              miss <= miss + 1'b1;
            end
          end
        end
        default: state <= UNLOCK;
      endcase
    end
  end

endmodule

// File: rtl/multi_lock_monitor.sv
// NUM_CH independent lock monitors plus the all-locked / any-lost summaries.
module multi_lock_monitor
  import multi_lock_monitor_pkg::*;
#(
  parameter int NUM_CH     = 1,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 255,
  parameter int MISS_LIMIT = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_lock_monitor_if.slave  bus
);

  logic [NUM_CH-1:0]   ch_locked;
  logic [NUM_CH-1:0]   ch_lost;
  logic [2*NUM_CH-1:0] ch_state_vec;
  lock_state_e         ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lock_monitor_ch #(
      .LOCK_COUNT (LOCK_COUNT),
      .TIMEOUT    (TIMEOUT),
      .MISS_LIMIT (MISS_LIMIT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (bus.clear[i]),
      .rise_edge (bus.rise_edge[i]),
      .locked    (ch_locked[i]),
      .lock_lost (ch_lost[i]),
      .state     (ch_state[i])
    );
    assign ch_state_vec[2*i +: 2] = 2'(ch_state[i]);
  end

  assign bus.locked     = ch_locked;
  assign bus.lock_lost  = ch_lost;
  assign bus.state_o    = ch_state_vec;
  assign bus.all_locked = &ch_locked;
  assign bus.any_lost   = |ch_lost;

endmodule
